if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the decode/register-read stage. Holds the program counter, drives the instruction-memory word address, and captures the fetched word plus PC+4 into the IF/ID pipeline register consumed by decode. Handles stall, flush, branch and jump redirects from decode, and halts with a sticky fault on a misaligned branch target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- IMEM_AWIDTH, 10, width of the instruction-memory word address.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and IF/ID register.
- Flush  in  1  load bubble into IF/ID.
- BrTaken  in  1  conditional-branch redirect request from decode.
- BrTarget  in  32  branch target byte address.
- Jump  in  1  J/JAL redirect request from decode.
- JumpIndex  in  26  instr_index field of the jump in decode.
- IMemAddr  out  IMEM_AWIDTH  word address = PC[IMEM_AWIDTH+1:2].
- IMemData  in  32  combinational read data for IMemAddr.
- PC  out  32  current fetch PC.
- Ins  out  32  IF/ID instruction to decode.
- IdPC4  out  32  IF/ID PC+4 of Ins.
- IdValid  out  1  IF/ID holds a real instruction.
- Fault  out  1  sticky misaligned-branch fault.

## Operation
- States: BOOT, RUN, HALT. Reset -> BOOT. BOOT -> RUN on first edge with RST high. RUN -> HALT on misaligned branch. HALT exits only by reset.
- Redirect = Jump or BrTaken; Jump has priority over BrTaken when both high.
- Jump target = {IdPC4[31:28], JumpIndex, 2'b00}; always aligned.
- Misaligned branch: BrTaken=1, Jump=0, BrTarget[1:0]!=0 -> Fault<=1, state<=HALT, PC unchanged.
- PC next (priority): BOOT or HALT -> hold; aligned redirect -> target; Stall -> hold; else PC+4 (32-bit wrap, 0xFFFF_FFFC -> 0).
- IF/ID next (priority): BOOT or HALT -> bubble; Flush or any redirect (including misaligned) -> bubble; Stall -> hold; else Ins<=IMemData, IdPC4<=PC+4, IdValid<=1.
- Bubble: Ins<=0 (NOP), IdValid<=0, IdPC4 held.
- No branch delay slot: the word fetched in the redirect cycle is squashed.
- Redirect overrides Stall for both PC and IF/ID.

## Timing
- Reset (RST low, no clock needed): PC=RESET_PC, Ins=0, IdPC4=0, IdValid=0, Fault=0, state=BOOT. IMemAddr follows PC combinationally.
- First edge after RST rises: BOOT->RUN, PC held at RESET_PC, IF/ID bubble.
- Fetch latency: word at PC=A appears on Ins with IdPC4=A+4 one edge after the cycle PC==A in RUN with Stall=0 and no redirect/flush.
- Redirect sampled in cycle N: PC=target after edge N; Ins is bubble after edge N; imem[target] on Ins after edge N+1.
- Stall held k cycles: PC, Ins, IdPC4, IdValid frozen k cycles.
- RST asserted mid-run: all outputs return to reset values immediately, asynchronously.

## Test plan
- Reset release, imem[i]=0x100+i, no controls: cycle after release bubble (IdValid=0); then Ins=0x100,0x101,0x102 with IdPC4=4,8,12, IdValid=1.
- Stall=1 for 2 cycles while PC=0x8: PC stays 0x8, Ins/IdPC4 frozen at 0x101/0x8; after release Ins=0x102, PC=0xC.
- BrTaken=1, BrTarget=0x40 while PC=0x10, Stall=1: PC=0x40, next Ins=0 with IdValid=0, following Ins=imem[0x10].
- Jump=1 and BrTaken=1 with IdPC4=0x1000_0008, JumpIndex=26'h10, BrTarget=0x80: PC=0x1000_0040 (jump wins).
- BrTaken=1, BrTarget=0x42: Fault=1, PC frozen, IdValid=0 and Ins=0 indefinitely; RST low clears Fault and PC=RESET_PC.
- RST pulled low between clock edges while IdValid=1: Ins=0, IdValid=0, PC=RESET_PC before next edge.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage of a 5-stage MIPS pipeline. Holds the
//               program counter, drives the instruction-memory word address,
//               and registers the fetched word plus PC+4 into IF/ID. Handles
//               stall, flush, and branch/jump redirects from decode. A
//               misaligned branch target halts fetch with a sticky fault.
// Ports       : CLK        - clock, rising edge
//               RST        - asynchronous active-low reset
//               Stall      - hold PC and IF/ID
//               Flush      - load bubble into IF/ID
//               BrTaken    - conditional-branch redirect request
//               BrTarget   - branch target byte address
//               Jump       - J/JAL redirect request (beats BrTaken)
//               JumpIndex  - instr_index field of the jump
//               IMemAddr   - instruction-memory word address (PC[AW+1:2])
//               IMemData   - combinational instruction-memory read data
//               PC         - current fetch PC
//               Ins        - IF/ID instruction
//               IdPC4      - IF/ID PC+4
//               IdValid    - IF/ID holds a real instruction
//               Fault      - sticky misaligned-branch fault
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_AWIDTH = 10
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Stall,
    input  logic                   Flush,
    input  logic                   BrTaken,
    input  logic [31:0]            BrTarget,
    input  logic                   Jump,
    input  logic [25:0]            JumpIndex,
    output logic [IMEM_AWIDTH-1:0] IMemAddr,
    input  logic [31:0]            IMemData,
    output logic [31:0]            PC,
    output logic [31:0]            Ins,
    output logic [31:0]            IdPC4,
    output logic                   IdValid,
    output logic                   Fault
);

    localparam logic [1:0] c_st_boot = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ins;
    logic [31:0] r_idpc4;
    logic        r_idvalid;
    logic        r_fault;

    logic        w_redirect;
    logic        w_misalign;
    logic [31:0] w_target;
    logic [31:0] w_pc4;
    logic [31:0] w_pc_nxt;
    logic        w_ifid_bubble;
    logic        w_ifid_load;
    logic        w_fault_set;

    assign w_redirect = Jump | BrTaken;
    // Jump targets are always word aligned; only a lone branch can misalign.
    assign w_misalign = BrTaken & ~Jump & (BrTarget[1:0] != 2'b00);
    // Jump region comes from the PC+4 of the jump itself, which sits in IF/ID.
    assign w_target   = Jump ? {r_idpc4[31:28], JumpIndex, 2'b00} : BrTarget;
    assign w_pc4      = r_pc + 32'd4;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_boot: w_state_nxt = c_st_run;
            c_st_run:  if (w_misalign) w_state_nxt = c_st_halt;
            c_st_halt: w_state_nxt = c_st_halt;
            default:   w_state_nxt = c_st_boot;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_nxt      = r_pc;
        w_ifid_bubble = 1'b0;
        w_ifid_load   = 1'b0;
        w_fault_set   = 1'b0;
        if (r_state == c_st_run) begin
            if (w_misalign) begin
                // PC frozen, squash the word fetched this cycle.
                w_fault_set   = 1'b1;
                w_ifid_bubble = 1'b1;
            end else if (w_redirect) begin
                // Redirect beats Stall; no delay slot, so squash this fetch.
                w_pc_nxt      = w_target;
                w_ifid_bubble = 1'b1;
            end else begin
                if (!Stall) begin
                    w_pc_nxt = w_pc4;
                end
                if (Flush) begin
                    w_ifid_bubble = 1'b1;
                end else if (!Stall) begin
                    w_ifid_load = 1'b1;
                end
            end
        end else begin
            w_ifid_bubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // PC, IF/ID register and fault flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pc      <= RESET_PC;
            r_ins     <= 32'd0;
            r_idpc4   <= 32'd0;
            r_idvalid <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
            if (w_ifid_bubble) begin
                // NOP bubble; IdPC4 deliberately left as-is.
                r_ins     <= 32'd0;
                r_idvalid <= 1'b0;
            end else if (w_ifid_load) begin
                r_ins     <= IMemData;
                r_idpc4   <= w_pc4;
                r_idvalid <= 1'b1;
            end
        end
    end

    assign IMemAddr = r_pc[IMEM_AWIDTH+1:2];
    assign PC       = r_pc;
    assign Ins      = r_ins;
    assign IdPC4    = r_idpc4;
    assign IdValid  = r_idvalid;
    assign Fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam int c_aw = 10;

    logic            CLK;
    logic            RST;
    logic            Stall;
    logic            Flush;
    logic            BrTaken;
    logic [31:0]     BrTarget;
    logic            Jump;
    logic [25:0]     JumpIndex;
    logic [c_aw-1:0] IMemAddr;
    logic [31:0]     IMemData;
    logic [31:0]     PC;
    logic [31:0]     Ins;
    logic [31:0]     IdPC4;
    logic            IdValid;
    logic            Fault;

    logic [31:0] imem [0:(1<<c_aw)-1];
    int checks = 0;
    int errors = 0;

    if_stage #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_AWIDTH (c_aw)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Stall     (Stall),
        .Flush     (Flush),
        .BrTaken   (BrTaken),
        .BrTarget  (BrTarget),
        .Jump      (Jump),
        .JumpIndex (JumpIndex),
        .IMemAddr  (IMemAddr),
        .IMemData  (IMemData),
        .PC        (PC),
        .Ins       (Ins),
        .IdPC4     (IdPC4),
        .IdValid   (IdValid),
        .Fault     (Fault)
    );

    assign IMemData = imem[IMemAddr];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pc4, input logic vld);
        check({tag, ".PC"}, PC, pc);
        check({tag, ".Ins"}, Ins, ins);
        check({tag, ".IdPC4"}, IdPC4, pc4);
        check({tag, ".IdValid"}, {31'd0, IdValid}, {31'd0, vld});
    endtask

    initial begin
        for (int i = 0; i < (1 << c_aw); i++) imem[i] = 32'h100 + i;
        RST = 1'b0; Stall = 1'b0; Flush = 1'b0; BrTaken = 1'b0;
        BrTarget = 32'd0; Jump = 1'b0; JumpIndex = 26'd0;

        // Reset state
        #2;
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.Fault", {31'd0, Fault}, 32'd0);
        check("reset.IMemAddr", {22'd0, IMemAddr}, 32'd0);

        // Release between edges; first edge is BOOT -> RUN with bubble
        RST = 1'b1;
        step();
        check_ifid("boot", 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        check_ifid("fetch0", 32'h4, 32'h100, 32'h4, 1'b1);
        step();
        check_ifid("fetch1", 32'h8, 32'h101, 32'h8, 1'b1);

        // Stall two cycles at PC=0x8
        Stall = 1'b1;
        step();
        check_ifid("stall1", 32'h8, 32'h101, 32'h8, 1'b1);
        step();
        check_ifid("stall2", 32'h8, 32'h101, 32'h8, 1'b1);
        Stall = 1'b0;
        step();
        check_ifid("unstall", 32'hC, 32'h102, 32'hC, 1'b1);
        step();
        check_ifid("fetch3", 32'h10, 32'h103, 32'h10, 1'b1);

        // Branch while stalled: redirect wins, fetch squashed
        BrTaken = 1'b1; BrTarget = 32'h40; Stall = 1'b1;
        step();
        check_ifid("branch", 32'h40, 32'h0, 32'h10, 1'b0);
        BrTaken = 1'b0; Stall = 1'b0;
        step();
        check_ifid("br_tgt", 32'h44, 32'h110, 32'h44, 1'b1);

        // Move into the 0x1xxx_xxxx region so the jump region bits matter
        BrTaken = 1'b1; BrTarget = 32'h1000_0004;
        step();
        check_ifid("br_hi", 32'h1000_0004, 32'h0, 32'h44, 1'b0);
        BrTaken = 1'b0;
        step();
        check_ifid("fetch_hi", 32'h1000_0008, 32'h101, 32'h1000_0008, 1'b1);

        // Jump and branch together: jump wins
        Jump = 1'b1; JumpIndex = 26'h10; BrTaken = 1'b1; BrTarget = 32'h80;
        step();
        check_ifid("jump", 32'h1000_0040, 32'h0, 32'h1000_0008, 1'b0);
        Jump = 1'b0; BrTaken = 1'b0;
        step();
        check_ifid("jmp_tgt", 32'h1000_0044, 32'h110, 32'h1000_0044, 1'b1);

        // Flush: PC advances, IF/ID bubble with IdPC4 held
        Flush = 1'b1;
        step();
        check_ifid("flush", 32'h1000_0048, 32'h0, 32'h1000_0044, 1'b0);
        Flush = 1'b0;

        // PC wrap from 0xFFFF_FFFC
        BrTaken = 1'b1; BrTarget = 32'hFFFF_FFFC;
        step();
        check_ifid("br_top", 32'hFFFF_FFFC, 32'h0, 32'h1000_0044, 1'b0);
        BrTaken = 1'b0;
        step();
        check_ifid("wrap", 32'h0, 32'h4FF, 32'h0, 1'b1);
        step();
        check_ifid("post_wrap", 32'h4, 32'h100, 32'h4, 1'b1);

        // Misaligned branch: halt with sticky fault
        BrTaken = 1'b1; BrTarget = 32'h42;
        step();
        check_ifid("misalign", 32'h4, 32'h0, 32'h4, 1'b0);
        check("misalign.Fault", {31'd0, Fault}, 32'd1);
        BrTaken = 1'b0;
        Jump = 1'b1; JumpIndex = 26'h20;
        for (int k = 0; k < 3; k++) begin
            step();
            check_ifid("halt", 32'h4, 32'h0, 32'h4, 1'b0);
            check("halt.Fault", {31'd0, Fault}, 32'd1);
        end
        Jump = 1'b0;

        // Reset clears the fault without a clock edge
        #2;
        RST = 1'b0;
        #1;
        check("rst_halt.Fault", {31'd0, Fault}, 32'd0);
        check("rst_halt.PC", PC, 32'h0);
        RST = 1'b1;
        step();
        check_ifid("reboot", 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        check_ifid("refetch", 32'h4, 32'h100, 32'h4, 1'b1);

        // Asynchronous reset mid-cycle while IdValid=1
        #2;
        RST = 1'b0;
        #1;
        check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        check("async_rst.Fault", {31'd0, Fault}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
